// File: rtl/pcie_pio_burst_ram.sv
// Burst-capable Avalon-MM on-chip RAM slave terminating the PCIe PIO bridge master port.
// Deterministic 1-cycle registered read latency; RAM contents survive reset.
module pcie_pio_burst_ram #(
  parameter int ADDR_W  = 64,
  parameter int DATA_W  = 512,
  parameter int BURST_W = 4,
  parameter int DEPTH   = 256
) (
  input  logic                pcie_clk,
  input  logic                pcie_rst,
  input  logic [ADDR_W-1:0]   avalon_slave_address,
  input  logic                avalon_slave_read,
  input  logic                avalon_slave_write,
  input  logic [DATA_W-1:0]   avalon_slave_writedata,
  input  logic [DATA_W/8-1:0] avalon_slave_byteenable,
  input  logic [BURST_W-1:0]  avalon_slave_burstcount,
  output logic                avalon_slave_waitrequest,
  output logic [DATA_W-1:0]   avalon_slave_readdata,
  output logic                avalon_slave_readdatavalid,
  output logic                protocol_err
);

  localparam int BE_W      = DATA_W / 8;
  localparam int OFS_W     = $clog2(BE_W);
  localparam int IDX_W     = $clog2(DEPTH);
  localparam int CNT_W     = BURST_W - 1;
  localparam int MAX_BURST = 2 ** (BURST_W - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WR   = 2'd1;
  localparam logic [1:0] ST_RD   = 2'd2;

  logic [DATA_W-1:0] r_ram [DEPTH];

  logic [1:0]        r_state;
  logic [IDX_W-1:0]  r_idx;
  logic [CNT_W-1:0]  r_beats_left;
  logic              r_waitrequest;
  logic              r_rdv;
  logic              r_perr;
  logic [DATA_W-1:0] r_readdata;

  logic [IDX_W-1:0]   w_addr_idx;
  logic [BURST_W-1:0] w_bc_m1;
  logic               w_bc_ok;
  logic [CNT_W-1:0]   w_beats_m1;
  logic               w_idle_open;
  logic               w_idle_wr;
  logic               w_idle_rd;
  logic               w_burst_wr;
  logic               w_ram_we;
  logic [IDX_W-1:0]   w_wr_idx;
  logic               w_perr;
  logic               w_unused;

  assign w_addr_idx = avalon_slave_address[OFS_W +: IDX_W];
  assign w_bc_m1    = avalon_slave_burstcount - BURST_W'(1);
  assign w_bc_ok    = (avalon_slave_burstcount != '0) &&
                      (avalon_slave_burstcount <= BURST_W'(MAX_BURST));
  assign w_beats_m1 = w_bc_ok ? w_bc_m1[CNT_W-1:0] : '0;

  // Out-of-range burstcounts degrade to single beats so the host never wedges the slave.
  assign w_idle_open = (r_state == ST_IDLE) && !r_waitrequest;
  assign w_idle_wr   = w_idle_open && avalon_slave_write;
  assign w_idle_rd   = w_idle_open && avalon_slave_read && !avalon_slave_write;
  assign w_burst_wr  = (r_state == ST_WR) && avalon_slave_write;
  assign w_ram_we    = w_idle_wr || w_burst_wr;
  assign w_wr_idx    = (r_state == ST_IDLE) ? w_addr_idx : r_idx;

  assign w_perr = (w_idle_open && (avalon_slave_read || avalon_slave_write) &&
                   (!w_bc_ok || (avalon_slave_read && avalon_slave_write))) ||
                  ((r_state == ST_WR) && avalon_slave_read);

  assign w_unused = ^{avalon_slave_address[ADDR_W-1:OFS_W+IDX_W],
                      avalon_slave_address[OFS_W-1:0], w_bc_m1[BURST_W-1]};

  // NOTE: the RAM array has no reset on purpose; contents must survive pcie_rst and a
  // reset term would also stop it mapping onto block RAM.
  always_ff @(posedge pcie_clk) begin
    if (w_ram_we) begin
      for (int k = 0; k < BE_W; k++) begin
        if (avalon_slave_byteenable[k]) begin
          r_ram[w_wr_idx][8*k +: 8] <= avalon_slave_writedata[8*k +: 8];
        end
      end
    end
  end

  // waitrequest is a flop so it reads 1 throughout reset and drops one edge after release.
  always_ff @(posedge pcie_clk or posedge pcie_rst) begin
    if (pcie_rst) begin
      r_state       <= ST_IDLE;
      r_idx         <= '0;
      r_beats_left  <= '0;
      r_waitrequest <= 1'b1;
      r_rdv         <= 1'b0;
      r_perr        <= 1'b0;
      r_readdata    <= '0;
    end else begin
      r_perr <= w_perr;
      r_rdv  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_waitrequest <= 1'b0;
          if (w_idle_wr) begin
            if (w_beats_m1 != '0) begin
              r_state      <= ST_WR;
              r_idx        <= w_addr_idx + IDX_W'(1);
              r_beats_left <= w_beats_m1;
            end
          end else if (w_idle_rd) begin
            r_state       <= ST_RD;
            r_waitrequest <= 1'b1;
            r_readdata    <= r_ram[w_addr_idx];
            r_rdv         <= 1'b1;
            r_idx         <= w_addr_idx + IDX_W'(1);
            r_beats_left  <= w_beats_m1;
          end
        end
        ST_WR: begin
          if (avalon_slave_write) begin
            r_idx        <= r_idx + IDX_W'(1);
            r_beats_left <= r_beats_left - CNT_W'(1);
            if (r_beats_left == CNT_W'(1)) begin
              r_state <= ST_IDLE;
            end
          end
        end
        ST_RD: begin
          if (r_beats_left != '0) begin
            r_readdata   <= r_ram[r_idx];
            r_rdv        <= 1'b1;
            r_idx        <= r_idx + IDX_W'(1);
            r_beats_left <= r_beats_left - CNT_W'(1);
          end else begin
            r_state       <= ST_IDLE;
            r_waitrequest <= 1'b0;
          end
        end
        default: begin
          r_state       <= ST_IDLE;
          r_waitrequest <= 1'b0;
        end
      endcase
    end
  end

  assign avalon_slave_waitrequest   = r_waitrequest;
  assign avalon_slave_readdata      = r_readdata;
  assign avalon_slave_readdatavalid = r_rdv;
  assign protocol_err               = r_perr;

endmodule
